lsb_mont_exp: RTL
=================

// Module: lsb_mont_exp
// PURPOSE
//  LSB-first Montgomery modular exponentiation controller for the RSA datapath.
//  Computes M^E mod N by sequencing one external radix-4 Montgomery multiplier
//  (MA) via its start/finish handshake: one conditional multiply and one square
//  per exponent bit. Sits directly upstream of the MA; consumes the
//  pre-processor's T = M*2^WIDTH mod N and feeds the result to the output stage.
// PARAMETERS
//  WIDTH   256  operand width of N, T, result and MA operands (MA is fixed at 256)
//  E_BITS  256  exponent width = number of loop iterations (constant-time)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high; same net as the MA's reset
//  start      in   1      one-cycle request; sampled only in IDLE
//  N_i        in   WIDTH  modulus; odd, 1 < N < 2^WIDTH (precondition)
//  E_i        in   E_BITS exponent
//  T_i        in   WIDTH  M in Montgomery form, T < N (precondition)
//  result     out  WIDTH  M^E mod N, registered, valid from finish onward
//  finish     out  1      one-cycle pulse when result becomes valid
//  busy       out  1      high from accepted start until the finish cycle inclusive
//  ma_start   out  1      one-cycle pulse launching one MA operation
//  ma_a       out  WIDTH  MA operand A (registered, held stable while MA runs)
//  ma_b       out  WIDTH  MA operand B (registered, held stable while MA runs)
//  ma_n       out  WIDTH  MA modulus (latched N)
//  ma_v       in   WIDTH  MA result, valid in the cycle ma_finish is high
//  ma_finish  in   1      MA done pulse; one cycle
// BEHAVIOUR
//  - Reset: state=IDLE; result, m, t, ma_a, ma_b, ma_n = 0; bit counter = 0;
//    finish, busy, ma_start = 0.
//  - Algorithm: m=1, t=T. For k=0..E_BITS-1: if E[k], m=MA(m,t); then t=MA(t,t).
//    result=m. m stays in the normal domain because each MA removes one R.
//  - IDLE: on start, latch N_i, E_i (into shift reg), T_i; m<=1; t<=T_i;
//    busy<=1; go to BIT.
//  - BIT: if e_sh[0], ma_a<=m, ma_b<=t -> MUL_GO; else ma_a<=t, ma_b<=t -> SQR_GO.
//  - MUL_GO / SQR_GO: ma_start=1 for exactly this cycle -> MUL_WAIT / SQR_WAIT.
//  - MUL_WAIT: on ma_finish, m<=ma_v; ma_a<=t, ma_b<=t -> SQR_GO.
//  - SQR_WAIT: on ma_finish, t<=ma_v; shift e_sh right by 1; count++.
//    If count == E_BITS-1 (last bit) -> DONE, else -> BIT.
//  - DONE: result<=m; finish=1 for one cycle; busy drops the next cycle -> IDLE.
//  - ma_start is never asserted while a WAIT state is pending. ma_finish outside
//    WAIT states is ignored.
//  - start while busy is ignored; inputs may change freely after acceptance.
//  - E=0: exactly E_BITS squares, no multiplies; result=1.
//  - Latency: (E_BITS + popcount(E)) MA operations, each L_MA + 1 cycles
//    (GO + wait), plus one BIT cycle per bit and 2 cycles for IDLE/DONE.
//  - Reset mid-operation: abort immediately to IDLE with reset values; no
//    finish pulse; the MA is reset by the same net.
//  - result holds its value until the next finish; it is not cleared on start.
// STRUCTURE
//  - Shared package: WIDTH, E_BITS, state encoding (IDLE, BIT, MUL_GO, MUL_WAIT,
//    SQR_GO, SQR_WAIT, DONE), and the counter width clog2(E_BITS).
//  - One natural sub-module: exp_bit_shifter (load, shift, count, last_bit flag).
//  - The MA instance lives in the parent; this block owns no arithmetic.
// TESTING (bench uses a behavioural MA: V = A*B*R^-1 mod N, fixed 130-cycle latency)
//  1 N=13, T=2*2^256 mod 13, E=5 -> result=6, one finish pulse, 258 ma_start pulses.
//  2 N=13, T as in 1, E=0 -> result=1, 256 ma_start pulses, all with ma_a==ma_b.
//  3 N=2^255+95 (odd), T for M=3, E=2^256-1 -> result matches golden model;
//    512 MA ops.
//  4 Start pulsed again in cycle 50 and in every WAIT state -> ignored; result
//    and count same as an undisturbed run.
//  5 Reset asserted mid-run in MUL_WAIT -> next cycle: IDLE, busy=0, ma_start=0,
//    no finish; new start then gives a correct result.
//  6 Spurious ma_finish in IDLE/BIT -> no state or m/t change; ma_start is
//    1 cycle wide, with ma_a/ma_b stable from GO until ma_finish.

Source files
------------

// File: rtl/lsb_mont_exp_pkg.sv
// Shared constants and FSM encoding for the LSB-first Montgomery exponentiation controller.
package lsb_mont_exp_pkg;
  localparam int WIDTH  = 256;
  localparam int E_BITS = 256;
  localparam int CNT_W  = (E_BITS > 1) ? $clog2(E_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIT,
    S_MUL_GO,
    S_MUL_WAIT,
    S_SQR_GO,
    S_SQR_WAIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/lsb_mont_exp_bit_shifter.sv
// Exponent shift register with iteration counter; bit 0 is the exponent bit being processed.
module lsb_mont_exp_bit_shifter
  import lsb_mont_exp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [E_BITS-1:0] e_in,
  output logic              cur_bit,
  output logic              last_bit
);

  logic [E_BITS-1:0] e_sh;
  logic [CNT_W-1:0]  count;

  // Load the exponent on accept; advance one bit per completed square.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_sh  <= '0;
      count <= '0;
    end else if (load) begin
      e_sh  <= e_in;
      count <= '0;
    end else if (shift) begin
      e_sh  <= e_sh >> 1;
      count <= count + CNT_W'(1);
    end
  end

  assign cur_bit  = e_sh[0];
  // Sampled while the final square is finishing, before the counter advances.
  assign last_bit = (count == CNT_W'(E_BITS - 1));

endmodule

// File: rtl/lsb_mont_exp.sv
// LSB-first Montgomery exponentiation controller: sequences one external MA for
// a conditional multiply and a square per exponent bit (constant iteration count).
module lsb_mont_exp
  import lsb_mont_exp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  N_i,
  input  logic [E_BITS-1:0] E_i,
  input  logic [WIDTH-1:0]  T_i,
  output logic [WIDTH-1:0]  result,
  output logic              finish,
  output logic              busy,
  output logic              ma_start,
  output logic [WIDTH-1:0]  ma_a,
  output logic [WIDTH-1:0]  ma_b,
  output logic [WIDTH-1:0]  ma_n,
  input  logic [WIDTH-1:0]  ma_v,
  input  logic              ma_finish
);

  state_t           state, state_n;
  logic [WIDTH-1:0] m, t;
  logic             cur_bit, last_bit;
  logic             accept, sqr_done;

  assign accept   = (state == S_IDLE) && start;
  assign sqr_done = (state == S_SQR_WAIT) && ma_finish;

  lsb_mont_exp_bit_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift    (sqr_done),
    .e_in     (E_i),
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  // Control outputs decode straight from the state register.
  assign ma_start = (state == S_MUL_GO) || (state == S_SQR_GO);
  assign finish   = (state == S_DONE);
  assign busy     = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; ma_finish only matters in the two WAIT states.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start) state_n = S_BIT;
      S_BIT:      state_n = cur_bit ? S_MUL_GO : S_SQR_GO;
      S_MUL_GO:   state_n = S_MUL_WAIT;
      S_MUL_WAIT: if (ma_finish) state_n = S_SQR_GO;
      S_SQR_GO:   state_n = S_SQR_WAIT;
      S_SQR_WAIT: if (ma_finish) state_n = last_bit ? S_DONE : S_BIT;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Datapath registers: operands are only written outside the GO/WAIT window,
  // so ma_a/ma_b stay stable for the whole MA operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      m      <= '0;
      t      <= '0;
      result <= '0;
      ma_a   <= '0;
      ma_b   <= '0;
      ma_n   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ma_n <= N_i;
          m    <= WIDTH'(1);
          t    <= T_i;
        end
        S_BIT: begin
          ma_a <= cur_bit ? m : t;
          ma_b <= t;
        end
        S_MUL_WAIT: if (ma_finish) begin
          m    <= ma_v;
          ma_a <= t;
          ma_b <= t;
        end
        S_SQR_WAIT: if (ma_finish) begin
          t <= ma_v;
          // m is final once the last multiply has landed; publish it with DONE.
          if (last_bit) result <= m;
        end
        default: ;
      endcase
    end
  end

endmodule
